read_control: RTL and testbench
===============================

Name: read_control

Overview:
Read-side controller of the synchronous FIFO. It pairs with the write-side controller: it consumes the write pointer, owns the read pointer, and issues reads to the synchronous-read memory (1-cycle latency). It presents a first-word-fall-through valid/ready interface to the downstream consumer through a 2-entry output buffer, giving full throughput and no combinational path from i_ready_d to memory data.

Parameters:
AW, 10, address width; memory depth 2^AW, pointers AW+1 bits (MSB = wrap bit)
DW, 32, data width

Ports:
i_clk  input  1  clock; single clock domain
i_rst_n  input  1  asynchronous reset, active low
i_ready_d  input  1  consumer accepts o_rdata this cycle
i_almostempty_lvl  input  AW  o_almostempty asserts when words available <= this level
i_wptr  input  AW+1  write pointer from the write-side controller
i_rdata  input  DW  memory read data, valid the cycle after o_ren
o_rptr  output  AW+1  read pointer, to the write-side controller
o_raddr  output  AW  memory read address = o_rptr[AW-1:0]
o_ren  output  1  memory read enable
o_rdata  output  DW  head-of-FIFO data
o_valid_d  output  1  o_rdata valid
o_almostempty  output  1  almost-empty flag
o_empty  output  1  no word available to the consumer

Behaviour:
- Reset (async assert, sync release): o_rptr=0, buffer count=0, rd_pend=0, both buffer entries=0, o_rdata=0, o_valid_d=0, o_empty=1, o_almostempty=1. Any in-flight read is discarded; mid-operation reset drops all buffered data.
- mem_empty = (i_wptr == o_rptr), full AW+1-bit compare.
- pop = o_valid_d & i_ready_d.
- o_ren (combinational) = ~mem_empty & ((buf_cnt + rd_pend - pop) <= 1). This guarantees the arriving word always has a buffer slot.
- On o_ren: o_rptr <= o_rptr + 1 (wraps 2^(AW+1)-1 -> 0, MSB toggles); rd_pend <= 1, else 0.
- Cycle after o_ren (rd_pend=1): i_rdata written into the buffer.
- Buffer FSM on buf_cnt:
  - EMPTY: arrival -> ONE.
  - ONE: arrival & ~pop -> TWO; pop & ~arrival -> EMPTY; both or neither -> ONE, with the head replaced by arriving data if both.
  - TWO: pop -> ONE, tail moves to head (an arrival in TWO is impossible by construction and is asserted in simulation).
- All outputs except o_ren, o_raddr are registered or derived from registers. o_rdata = head entry, o_valid_d = (buf_cnt != 0), o_empty = ~o_valid_d. o_rdata is held stable while o_valid_d & ~i_ready_d.
- Latency: word written to empty FIFO (i_wptr advances at edge N) -> o_ren in cycle N -> o_valid_d at edge N+2.
- Throughput: 1 word/cycle sustained with i_ready_d held high.
- avail = (i_wptr - o_rptr) + buf_cnt + rd_pend, computed in AW+2 bits (max 2^AW+2). o_almostempty = (avail <= i_almostempty_lvl), zero-extended compare. It is combinational from registered values and i_wptr.
- i_almostempty_lvl = 0 means o_almostempty only when fully empty.
- Simultaneous write (i_wptr change) and read: i_wptr is sampled in the current cycle only; no hazard, since each controller updates only its own pointer.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - buf_state_t enum {BUF_EMPTY, BUF_ONE, BUF_TWO};
  - a pointer-difference function (AW+1 subtraction) shared with the write-side almost-full logic.
- One sub-module, fifo_out_buffer: 2-entry FWFT buffer with inputs wr_en/wr_data/pop and outputs head data/count. read_control holds pointer, rd_pend, o_ren and flag logic.

Test Plan:
- Reset with i_wptr=0 -> o_empty=1, o_valid_d=0, o_ren=0, o_almostempty=1, o_rptr=0; async assert mid-burst clears outputs immediately.
- i_wptr 0->1 at edge N, i_rdata=0xA5A5A5A5 -> o_ren=1 in cycle N, o_valid_d=1 and o_rdata=0xA5A5A5A5 at edge N+2; o_rptr=1.
- i_wptr=8, i_ready_d=1 constant -> 8 consecutive pops, o_ren high 8 cycles back-to-back, data order preserved, o_empty=1 after last.
- i_wptr=8, i_ready_d=0 -> o_ren exactly twice, buf_cnt=2, o_rptr=2, o_rdata stable; release i_ready_d -> remaining 8 words in order, no loss or duplicate.
- AW=3, o_rptr=15, i_wptr=1 (wrapped) -> reads at addresses 7 then 0, o_rptr 15->0->1 and stops.
- i_almostempty_lvl=3, fill 5 words with ready low -> o_almostempty=0; pop until avail=3 -> o_almostempty=1 in that cycle.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO read/write controllers.
package sync_fifo_pkg;

    // Occupancy of the 2-entry first-word-fall-through output buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Widest pointer the difference helper handles.
    localparam int PTR_MAX_W = 32;

    // Modular pointer difference a - b, truncated to pw bits (pw = AW+1).
    // Callers zero-extend their pointers and cast the result back down.
    function automatic logic [PTR_MAX_W-1:0] ptr_diff(
        input logic [PTR_MAX_W-1:0] a,
        input logic [PTR_MAX_W-1:0] b,
        input int                   pw
    );
        logic [PTR_MAX_W-1:0] diff;
        logic [PTR_MAX_W-1:0] mask;
        diff = a - b;
        mask = (pw >= PTR_MAX_W) ? '1 : ((32'd1 << pw) - 32'd1);
        return diff & mask;
    endfunction

endpackage

// File: rtl/fifo_out_buffer.sv
// Two-entry first-word-fall-through buffer between the FIFO memory and the consumer.
module fifo_out_buffer
    import sync_fifo_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic [1:0]    o_count
);

    buf_state_t    state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;

    // Next-state and entry updates; the head always holds the oldest word.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (i_wr_en) begin
                    head_d  = i_wr_data;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (i_wr_en && i_pop) begin
                    head_d = i_wr_data;
                end else if (i_wr_en) begin
                    tail_d  = i_wr_data;
                    state_d = BUF_TWO;
                end else if (i_pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (i_pop) begin
                    head_d  = tail_q;
                    state_d = BUF_ONE;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    // Buffer registers; reset drops any buffered words.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Occupancy count decoded from the registered state.
    always_comb begin
        o_count = 2'd0;
        if (state_q == BUF_ONE) o_count = 2'd1;
        if (state_q == BUF_TWO) o_count = 2'd2;
    end

    assign o_head = head_q;

    // The read issue rule never lets a word arrive while both entries are full.
    a_no_write_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !((state_q == BUF_TWO) && i_wr_en));

endmodule

// File: rtl/read_control.sv
// Read-side controller of the synchronous FIFO: owns the read pointer, issues
// memory reads and presents a first-word-fall-through valid/ready interface.
module read_control
    import sync_fifo_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ready_d,
    input  logic [AW-1:0] i_almostempty_lvl,
    input  logic [AW:0]   i_wptr,
    input  logic [DW-1:0] i_rdata,
    output logic [AW:0]   o_rptr,
    output logic [AW-1:0] o_raddr,
    output logic          o_ren,
    output logic [DW-1:0] o_rdata,
    output logic          o_valid_d,
    output logic          o_almostempty,
    output logic          o_empty
);

    logic [AW:0]   rptr_q, rptr_d;
    logic          rd_pend_q, rd_pend_d;
    logic [1:0]    buf_cnt;
    logic          mem_empty;
    logic          pop;
    logic [2:0]    occ_after_pop;
    logic [AW:0]   mem_words;
    logic [AW+1:0] avail;

    fifo_out_buffer #(
        .DW (DW)
    ) u_out_buffer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (rd_pend_q),
        .i_wr_data (i_rdata),
        .i_pop     (pop),
        .o_head    (o_rdata),
        .o_count   (buf_cnt)
    );

    // Read issue: only fetch when the word will have a free buffer slot on arrival.
    always_comb begin
        mem_empty     = (i_wptr == rptr_q);
        pop           = o_valid_d & i_ready_d;
        occ_after_pop = {1'b0, buf_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
        o_ren         = ~mem_empty & (occ_after_pop <= 3'd1);
        rptr_d        = o_ren ? (rptr_q + 1'b1) : rptr_q;
        rd_pend_d     = o_ren;
    end

    // Pointer and in-flight flag; a read in flight at reset is discarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rptr_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            rptr_q    <= rptr_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Words available to the consumer: in memory, in flight and buffered.
    always_comb begin
        mem_words     = (AW+1)'(ptr_diff(32'(i_wptr), 32'(rptr_q), AW + 1));
        avail         = {1'b0, mem_words}
                      + {{AW{1'b0}}, buf_cnt}
                      + {{(AW+1){1'b0}}, rd_pend_q};
        o_almostempty = (avail <= {2'b00, i_almostempty_lvl});
    end

    assign o_rptr    = rptr_q;
    assign o_raddr   = rptr_q[AW-1:0];
    assign o_valid_d = (buf_cnt != 2'd0);
    assign o_empty   = ~o_valid_d;

endmodule

// File: tb/tb_read_control.sv
// Self-checking bench for read_control: directed latency/throughput/wrap/flag
// steps followed by randomized traffic against a word-queue reference model.
module tb_read_control;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_ready_d = 1'b0;
    logic [AW-1:0] i_almostempty_lvl = '0;
    logic [AW:0]   i_wptr = '0;
    logic [DW-1:0] i_rdata = '0;
    logic [AW:0]   o_rptr;
    logic [AW-1:0] o_raddr;
    logic          o_ren;
    logic [DW-1:0] o_rdata;
    logic          o_valid_d;
    logic          o_almostempty;
    logic          o_empty;

    read_control #(.AW(AW), .DW(DW)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_ready_d         (i_ready_d),
        .i_almostempty_lvl (i_almostempty_lvl),
        .i_wptr            (i_wptr),
        .i_rdata           (i_rdata),
        .o_rptr            (o_rptr),
        .o_raddr           (o_raddr),
        .o_ren             (o_ren),
        .o_rdata           (o_rdata),
        .o_valid_d         (o_valid_d),
        .o_almostempty     (o_almostempty),
        .o_empty           (o_empty)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous-read memory with one cycle of latency.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge i_clk) if (o_ren) i_rdata <= mem[o_raddr];

    // Reference model: every written word not yet popped, oldest first.
    logic [DW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int written = 0;
    int popped = 0;
    int ren_count = 0;
    int cyc_idx = 0;
    int ren_cycles[$];
    int ren_addrs[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[i_wptr[AW-1:0]] = d;
        exp_q.push_back(d);
        i_wptr = i_wptr + 1'b1;
        written++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        written = 0;
        popped  = 0;
    endtask

    // One clock cycle: check the current cycle against the model, then advance.
    task automatic tick();
        int avail;
        #1;
        avail = written - popped;
        if (o_ren) begin
            ren_count++;
            ren_cycles.push_back(cyc_idx);
            ren_addrs.push_back(int'(o_raddr));
        end
        chk("almostempty", o_almostempty, (avail <= int'(i_almostempty_lvl)));
        if (avail == 0) chk("valid_when_empty", o_valid_d, 0);
        if (o_valid_d) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", o_valid_d, 0);
            end else begin
                chk("head_data", o_rdata, exp_q[0]);
                if (i_ready_d) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
        @(posedge i_clk);
        #1;
        cyc_idx++;
    endtask

    initial begin
        int base;
        int start_pop;

        // Reset state
        #12;
        chk("rst_empty", o_empty, 1);
        chk("rst_valid", o_valid_d, 0);
        chk("rst_ren", o_ren, 0);
        chk("rst_almostempty", o_almostempty, 1);
        chk("rst_rptr", o_rptr, 0);
        chk("rst_rdata", o_rdata, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        tick();
        chk("idle_ren", o_ren, 0);

        // First-word latency
        push_word(32'hA5A5_A5A5);
        #1;
        chk("lat_ren", o_ren, 1);
        chk("lat_raddr", o_raddr, 0);
        tick();
        chk("lat_valid_n1", o_valid_d, 0);
        chk("lat_rptr", o_rptr, 1);
        tick();
        chk("lat_valid_n2", o_valid_d, 1);
        chk("lat_rdata", o_rdata, 32'hA5A5_A5A5);
        i_ready_d = 1'b1;
        tick();
        i_ready_d = 1'b0;

        // Full-rate burst with consumer always ready
        ren_count = 0;
        ren_cycles.delete();
        start_pop = popped;
        for (int i = 0; i < 8; i++) push_word($urandom);
        i_ready_d = 1'b1;
        repeat (14) tick();
        chk("burst_ren_count", ren_count, 8);
        if (ren_cycles.size() == 8) chk("burst_ren_span", ren_cycles[7] - ren_cycles[0], 7);
        chk("burst_pops", popped - start_pop, 8);
        chk("burst_empty", o_empty, 1);

        // Stalled consumer: only two reads issue, head held
        i_ready_d = 1'b0;
        ren_count = 0;
        base = int'(i_wptr);
        start_pop = popped;
        for (int i = 0; i < 8; i++) push_word($urandom);
        repeat (6) tick();
        chk("stall_ren_count", ren_count, 2);
        chk("stall_rptr", o_rptr, (base + 2) % (2 * DEPTH));
        chk("stall_valid", o_valid_d, 1);
        i_ready_d = 1'b1;
        repeat (14) tick();
        chk("stall_pops", popped - start_pop, 8);
        chk("stall_empty", o_empty, 1);

        // Advance the read pointer to 15, then write across the wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 7; i++) push_word($urandom);
            repeat (12) tick();
        end
        i_ready_d = 1'b0;
        tick();
        chk("pre_wrap_rptr", o_rptr, 15);
        push_word($urandom);
        push_word($urandom);
        #1;
        chk("wrap_ren", o_ren, 1);
        chk("wrap_raddr0", o_raddr, 7);
        ren_count = 0;
        ren_addrs.delete();
        i_ready_d = 1'b1;
        repeat (8) tick();
        chk("wrap_ren_count", ren_count, 2);
        if (ren_addrs.size() == 2) begin
            chk("wrap_addr_a", ren_addrs[0], 7);
            chk("wrap_addr_b", ren_addrs[1], 0);
        end
        chk("wrap_rptr", o_rptr, 1);
        chk("wrap_ren_stop", o_ren, 0);

        // Almost-empty threshold
        i_ready_d = 1'b0;
        i_almostempty_lvl = 3'd3;
        for (int i = 0; i < 5; i++) push_word($urandom);
        repeat (4) tick();
        chk("ae_above", o_almostempty, 0);
        i_ready_d = 1'b1;
        for (int i = 0; i < 10 && (written - popped) > 3; i++) tick();
        i_ready_d = 1'b0;
        #1;
        chk("ae_at_level", o_almostempty, 1);
        i_almostempty_lvl = 3'd0;
        #1;
        chk("ae_lvl0_nonempty", o_almostempty, 0);
        i_ready_d = 1'b1;
        repeat (8) tick();
        chk("ae_lvl0_empty", o_almostempty, 1);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) push_word($urandom);
        repeat (2) tick();
        #2;
        i_rst_n = 1'b0;
        i_wptr = '0;
        model_reset();
        #1;
        chk("arst_valid", o_valid_d, 0);
        chk("arst_empty", o_empty, 1);
        chk("arst_rptr", o_rptr, 0);
        chk("arst_rdata", o_rdata, 0);
        chk("arst_almostempty", o_almostempty, 1);
        chk("arst_ren", o_ren, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) i_almostempty_lvl = AW'($urandom_range(0, DEPTH - 1));
            i_ready_d = ($urandom_range(0, 3) != 0);
            if ((written - popped) < DEPTH && $urandom_range(0, 9) < 6) push_word($urandom);
            tick();
        end

        // Drain everything
        i_ready_d = 1'b1;
        for (int i = 0; i < 30 && popped != written; i++) tick();
        chk("drain_all", popped, written);
        chk("drain_empty", o_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
